// File: rtl/dct_tx_serializer.sv
// dct_tx_serializer: turns one coefficient block from dct_core into a byte
// stream for uart_tx, MSB byte first, with a one-deep pending slot and a
// sticky overflow flag for blocks that arrive while both slots are full.
// Optional feature: define DCT_TX_CHECKSUM_EN to append an XOR checksum byte
// after the data bytes of every frame.
module dct_tx_serializer #(
    parameter int NUM_BYTES   = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*NUM_BYTES-1:0] blk_data,
    input  logic                   blk_valid,
    input  logic                   tx_busy,
    output logic [7:0]             tx_byte,
    output logic                   tx_valid,
    output logic                   frame_done,
    output logic                   overflow,
    output logic                   idle
);

    localparam int BLK_W = 8 * NUM_BYTES;
`ifdef DCT_TX_CHECKSUM_EN
    localparam int FRAME_LEN = NUM_BYTES + 1;
`else
    localparam int FRAME_LEN = NUM_BYTES;
`endif
    // index must hold every byte position of a frame without wrapping
    localparam int IDX_W = $clog2(FRAME_LEN + 1);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_NEXT
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [BLK_W-1:0]   act_q, act_d;
    logic [BLK_W-1:0]   pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               tx_valid_q, tx_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;
    logic               idle_q, idle_d;
    logic               start;
    logic               is_last;
    logic [7:0]         cur_byte;
`ifdef DCT_TX_CHECKSUM_EN
    localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(NUM_BYTES);
    logic [7:0]         csum_q, csum_d;
`endif

    assign is_last = (idx_q == LAST_IDX);

    // byte presented to uart_tx: active register is shifted so the next
    // data byte is always at the top; the checksum slot sends the XOR
    always_comb begin
        cur_byte = act_q[BLK_W-1 -: 8];
`ifdef DCT_TX_CHECKSUM_EN
        if (idx_q == CSUM_IDX) begin
            cur_byte = csum_q;
        end
`endif
    end

    // block intake: active/pending slot management and overflow detection
    always_comb begin
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        overflow_d = overflow_q;
        start      = 1'b0;
        if (state_q == S_IDLE) begin
            if (pend_vld_q) begin
                // promote pending; a simultaneous new block refills the slot
                act_d      = pend_q;
                start      = 1'b1;
                pend_vld_d = 1'b0;
                if (blk_valid) begin
                    pend_d     = blk_data;
                    pend_vld_d = 1'b1;
                end
            end else if (blk_valid) begin
                act_d = blk_data;
                start = 1'b1;
            end
        end else begin
            // frame active (NEXT included): pending first, else drop
            if (blk_valid) begin
                if (!pend_vld_q) begin
                    pend_d     = blk_data;
                    pend_vld_d = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            if (state_q == S_NEXT && !is_last) begin
                act_d = act_q << 8;
            end
        end
    end

    // frame sequencing: send a byte, wait for the uart handshake, advance
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        tx_byte_d    = tx_byte_q;
        tx_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEND;
                    idx_d   = '0;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_byte_d  = cur_byte;
                    tx_valid_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // a uart that never raises busy still lets the frame finish
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_NEXT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (is_last) begin
                    frame_done_d = 1'b1;
                    idx_d        = '0;
                    state_d      = S_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_SEND;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        idle_d = (state_d == S_IDLE) && !pend_vld_d;
    end

`ifdef DCT_TX_CHECKSUM_EN
    // running XOR of the data bytes of the current frame
    always_comb begin
        csum_d = csum_q;
        if (start) begin
            csum_d = '0;
        end else if (state_q == S_SEND && !tx_busy && idx_q != CSUM_IDX) begin
            csum_d = csum_q ^ act_q[BLK_W-1 -: 8];
        end
    end
`endif

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            tmo_q        <= '0;
            act_q        <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            tx_byte_q    <= '0;
            tx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            idle_q       <= 1'b1;
`ifdef DCT_TX_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            tx_byte_q    <= tx_byte_d;
            tx_valid_q   <= tx_valid_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            idle_q       <= idle_d;
`ifdef DCT_TX_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign tx_byte    = tx_byte_q;
    assign tx_valid   = tx_valid_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign idle       = idle_q;

endmodule

// File: tb/tb_dct_tx_serializer.sv
// Directed bench for dct_tx_serializer with a simple uart_tx busy model.
module tb_dct_tx_serializer;

    localparam int NB  = 32;
    localparam int TMO = 16;
`ifdef DCT_TX_CHECKSUM_EN
    localparam int FL = NB + 1;
`else
    localparam int FL = NB;
`endif
    localparam int BUSY_CYC = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [8*NB-1:0] blk_data = '0;
    logic            blk_valid = 1'b0;
    logic            tx_busy = 1'b0;
    logic [7:0]      tx_byte;
    logic            tx_valid;
    logic            frame_done;
    logic            overflow;
    logic            idle;

    dct_tx_serializer #(.NUM_BYTES(NB), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .blk_data(blk_data), .blk_valid(blk_valid),
        .tx_busy(tx_busy), .tx_byte(tx_byte), .tx_valid(tx_valid),
        .frame_done(frame_done), .overflow(overflow), .idle(idle)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // uart model and output monitor, evaluated 1 time unit after each edge
    bit         uart_en = 1'b1;
    int         busy_cnt = 0;
    logic [7:0] got_q[$];
    int         fd_cnt = 0;
    longint     cyc = 0;
    longint     last_v = -1;
    int         min_gap = 1000000;
    int         last_gap = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (tx_valid) begin
            got_q.push_back(tx_byte);
            if (last_v >= 0) begin
                last_gap = int'(cyc - last_v);
                if (last_gap < min_gap) min_gap = last_gap;
            end
            last_v = cyc;
        end
        if (frame_done) fd_cnt++;
        if (busy_cnt != 0) busy_cnt--;
        if (tx_valid && uart_en) busy_cnt = BUSY_CYC;
        tx_busy = (busy_cnt != 0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [8*NB-1:0] mk(input int kind);
        logic [8*NB-1:0] d;
        logic [7:0] b;
        d = '0;
        for (int k = 0; k < NB; k++) begin
            if (kind == 0)      b = 8'(k);
            else if (kind == 1) b = 8'(255 - k);
            else                b = 8'hA5;
            d[8*NB-1-8*k -: 8] = b;
        end
        return d;
    endfunction

    task automatic send_blk(input logic [8*NB-1:0] d);
        blk_data  = d;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
    endtask

    task automatic wait_fd(input int target, input int budget, input string tag);
        int n = 0;
        while (fd_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, fd_cnt >= target}, 32'd1);
    endtask

    task automatic wait_bytes(input int target, input int budget, input string tag);
        int n = 0;
        while (got_q.size() < target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, got_q.size() >= target}, 32'd1);
    endtask

    task automatic chk_frame(input string tag, input logic [8*NB-1:0] d, input int start);
        logic [31:0] got;
        logic [7:0]  x;
        x = 8'h00;
        for (int k = 0; k < NB; k++) begin
            got = (start + k < got_q.size()) ? {24'b0, got_q[start+k]} : 32'h100;
            chk($sformatf("%s_b%0d", tag, k), got, {24'b0, d[8*NB-1-8*k -: 8]});
            x = x ^ d[8*NB-1-8*k -: 8];
        end
`ifdef DCT_TX_CHECKSUM_EN
        got = (start + NB < got_q.size()) ? {24'b0, got_q[start+NB]} : 32'h100;
        chk($sformatf("%s_csum", tag), got, {24'b0, x});
`endif
    endtask

    int base;
    int bfd;
    int sz;
    int n;

    initial begin
        // reset state
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);
        chk("rst_idle", {31'b0, idle}, 32'd1);
        chk("rst_tx_byte", {24'b0, tx_byte}, 32'd0);

        // single frame, bytes 00..1F
        base = got_q.size();
        bfd  = fd_cnt;
        send_blk(mk(0));
        chk("t1_idle_low", {31'b0, idle}, 32'd0);
        wait_fd(bfd + 1, 3000, "t1_fd_seen");
        repeat (50) tick();
        chk("t1_nbytes", 32'(got_q.size() - base), 32'(FL));
        chk_frame("t1", mk(0), base);
        chk("t1_fd_cnt", 32'(fd_cnt - bfd), 32'd1);
        chk("t1_overflow", {31'b0, overflow}, 32'd0);
        chk("t1_idle", {31'b0, idle}, 32'd1);

        // three blocks 5 cycles apart: second pending, third dropped
        base = got_q.size();
        bfd  = fd_cnt;
        send_blk(mk(0));
        repeat (4) tick();
        send_blk(mk(1));
        chk("t2_ovf_before", {31'b0, overflow}, 32'd0);
        repeat (4) tick();
        send_blk(mk(2));
        chk("t2_ovf_set", {31'b0, overflow}, 32'd1);
        wait_fd(bfd + 2, 3000, "t2_fd_seen");
        repeat (100) tick();
        chk("t2_fd_cnt", 32'(fd_cnt - bfd), 32'd2);
        chk("t2_nbytes", 32'(got_q.size() - base), 32'(2 * FL));
        chk_frame("t2a", mk(0), base);
        chk_frame("t2b", mk(1), base + FL);
        chk("t2_ovf_sticky", {31'b0, overflow}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t2_ovf_cleared", {31'b0, overflow}, 32'd0);

        // uart never busy: every byte advances on the ack timeout
        uart_en = 1'b0;
        repeat (15) tick();
        base = got_q.size();
        bfd  = fd_cnt;
        send_blk(mk(1));
        wait_fd(bfd + 1, 2000, "t3_fd_seen");
        chk("t3_nbytes", 32'(got_q.size() - base), 32'(FL));
        chk_frame("t3", mk(1), base);
        chk("t3_gap", 32'(last_gap), 32'(TMO + 2));
        uart_en = 1'b1;

        // reset after byte 5 aborts the frame; blk_valid during reset ignored
        base = got_q.size();
        send_blk(mk(1));
        wait_bytes(base + 6, 500, "t4_reach_b5");
        rst_n     = 1'b0;
        blk_data  = mk(2);
        blk_valid = 1'b1;
        tick();
        rst_n     = 1'b1;
        blk_valid = 1'b0;
        chk("t4_nbytes", 32'(got_q.size() - base), 32'd6);
        chk("t4_idle_rst", {31'b0, idle}, 32'd1);
        chk("t4_tx_byte_rst", {24'b0, tx_byte}, 32'd0);
        sz  = got_q.size();
        bfd = fd_cnt;
        repeat (300) tick();
        chk("t4_no_tx", 32'(got_q.size()), 32'(sz));
        chk("t4_no_fd", 32'(fd_cnt), 32'(bfd));
        chk("t4_idle", {31'b0, idle}, 32'd1);
        send_blk(mk(2));
        wait_fd(bfd + 1, 3000, "t4_fd_seen");
        chk_frame("t4", mk(2), sz);

        // blk_valid coincident with the final NEXT cycle goes to pending
        base = got_q.size();
        bfd  = fd_cnt;
        send_blk(mk(0));
        wait_bytes(base + FL, 1000, "t5_last_byte");
        n = 0;
        while (tx_busy && n < 50) begin
            tick();
            n++;
        end
        chk("t5_busy_fall", {31'b0, tx_busy}, 32'd0);
        tick();
        blk_data  = mk(2);
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        chk("t5_fd_coincident", {31'b0, frame_done}, 32'd1);
        chk("t5_idle_pending", {31'b0, idle}, 32'd0);
        tick();
        tick();
        chk("t5_restart_2cyc", {31'b0, tx_valid}, 32'd1);
        wait_fd(bfd + 2, 3000, "t5_fd_seen");
        repeat (20) tick();
        chk_frame("t5a", mk(0), base);
        chk_frame("t5b", mk(2), base + FL);
        chk("t5_overflow", {31'b0, overflow}, 32'd0);
`ifdef DCT_TX_CHECKSUM_EN
        chk("t5_csum_a5", (base + 2 * FL - 1 < got_q.size()) ? {24'b0, got_q[base+2*FL-1]} : 32'h100, 32'h00);
`endif

        chk("min_gap_ok", {31'b0, min_gap >= 3}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/dct_tx_serializer.md
DCT_TX_SERIALIZER -- requirements
Module: dct_tx_serializer

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 32, giving the bytes per block (block width = 8*NUM_BYTES).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, giving the maximum number of cycles to wait for tx_busy to rise after a tx_valid pulse.
REQ-003 SHALL use a single clock and a synchronous, active-low reset; ports as follows.
REQ-004 clk  input  1  rising-edge clock, sole clock domain.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 blk_data  input  8*NUM_BYTES  coefficient block from dct_core final_output.
REQ-007 blk_valid  input  1  one-cycle pulse from dct_core done; blk_data is valid in that cycle.
REQ-008 tx_busy  input  1  uart_tx busy.
REQ-009 tx_byte  output  8  byte to uart_tx.
REQ-010 tx_valid  output  1  one-cycle send request to uart_tx.
REQ-011 frame_done  output  1  one-cycle pulse after the last byte of a frame has fully transmitted.
REQ-012 overflow  output  1  sticky flag; set when a block is dropped.
REQ-013 idle  output  1  high when there is no active frame and no pending block.

Function
REQ-014 SHALL transmit each block MSB-first: byte k = blk_data[8*NUM_BYTES-1-8k -: 8], for k = 0..NUM_BYTES-1.
REQ-015 SHALL capture blk_data into the active register on the same edge blk_valid is sampled, whenever the FSM is IDLE.
REQ-016 SHALL hold one pending block: blk_valid while a frame is active and pending is empty -> capture into pending.
REQ-017 SHALL drop the block and set overflow when blk_valid arrives while a frame is active and pending is full; active and pending contents SHALL stay unchanged.
REQ-018 FSM states: IDLE, SEND, WAIT_ACK, WAIT_DONE, NEXT.
REQ-019 IDLE -> SEND on blk_valid, or on pending full; pending SHALL be moved to active and cleared in the same cycle.
REQ-020 SEND: when tx_busy==0, drive tx_byte = current byte, pulse tx_valid for exactly one cycle, go to WAIT_ACK; otherwise hold in SEND.
REQ-021 WAIT_ACK: tx_busy==1 -> WAIT_DONE; after ACK_TIMEOUT cycles with no busy -> NEXT (byte considered sent).
REQ-022 WAIT_DONE: tx_busy==0 -> NEXT.
REQ-023 NEXT: if byte index == NUM_BYTES-1 -> pulse frame_done and go to IDLE, index cleared; else increment index and go to SEND.
REQ-024 tx_byte SHALL remain stable from the tx_valid pulse until the next tx_valid pulse.
REQ-025 When frame_done pulses and pending is full, the FSM SHALL reach SEND within 2 cycles, with no blk_valid needed.
REQ-026 blk_valid in the same cycle as the NEXT->IDLE transition SHALL be captured into pending (frame still counts as active), never dropped while pending is empty.
REQ-027 The byte index counter SHALL be wide enough for NUM_BYTES and SHALL never wrap inside a frame.
REQ-028 Minimum spacing between tx_valid pulses SHALL be 3 cycles.

Reset
REQ-029 rst_n==0 at a clock edge SHALL force IDLE, index 0, pending empty, active cleared, tx_byte=0, tx_valid=0, frame_done=0, overflow=0, idle=1.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no further tx_valid and no frame_done; blk_valid is ignored while rst_n==0.

Configuration
REQ-031 Macro DCT_TX_CHECKSUM_EN defined: after byte NUM_BYTES-1, one extra byte equal to the XOR of all NUM_BYTES data bytes SHALL be sent through SEND/WAIT_ACK/WAIT_DONE, and frame_done SHALL follow that byte.
REQ-032 Macro DCT_TX_CHECKSUM_EN undefined: exactly NUM_BYTES bytes per frame, with no checksum logic present.

Verification
REQ-033 blk_data=256'h00010203...1F pulsed, tx_busy model 10 cycles per byte -> tx_byte sequence 00,01,...,1F, 32 tx_valid pulses, one frame_done, overflow=0.
REQ-034 Three blk_valid pulses 5 cycles apart during frame 1 -> block 2 sent after frame 1, block 3 dropped, overflow=1, exactly 2 frame_done.
REQ-035 tx_busy tied 0 -> each byte advances after ACK_TIMEOUT=16 cycles in WAIT_ACK; 32 bytes sent, frame_done asserted.
REQ-036 rst_n low for 1 cycle after byte 5 -> no further tx_valid, idle=1; a new blk_valid then restarts from byte 0.
REQ-037 DCT_TX_CHECKSUM_EN defined, blk_data all bytes 8'hA5 -> 33 bytes sent, last byte 8'h00; with blk_data bytes 00..1F, last byte 8'h00.
REQ-038 blk_valid coincident with the last byte's NEXT cycle -> block captured into pending and transmitted next, overflow stays 0.
